// File: rtl/apu_song_sequencer.sv
// Frame-driven song sequencer: walks a packed event stream in song ROM and issues
// note writes to the APU channel register port, advancing rows on the frame tempo.
module apu_song_sequencer #(
    parameter int ROM_ADDR_WIDTH = 10,
    parameter int TICKS_PER_ROW  = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_frame_pulse,
    output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
    input  logic [15:0]               i_rom_data,
    output logic                      o_wr_valid,
    input  logic                      i_wr_ready,
    output logic [1:0]                o_wr_channel,
    output logic [6:0]                o_wr_note,
    output logic [3:0]                o_wr_volume,
    output logic [3:0]                o_mixer,
    output logic                      o_playing,
    output logic                      o_fault
);

    // state    | meaning
    // IDLE     | stopped; pc/mixer/timers cleared
    // FETCH    | ROM sees pc
    // DECODE   | act on the returned event word
    // ISSUE    | hold channel write until accepted
    // WAIT_ROW | count down row boundaries of a WAIT event
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_ROW
    } state_t;

    localparam int TW = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_ROW - 1);

    localparam logic [1:0] OP_NOTE_ON  = 2'b00;
    localparam logic [1:0] OP_NOTE_OFF = 2'b01;
    localparam logic [1:0] OP_WAIT     = 2'b10;
    localparam logic [1:0] OP_JUMP     = 2'b11;

    state_t                    state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [TW-1:0]             tick_q, tick_d;
    logic [11:0]               rows_left_q, rows_left_d;
    logic                      row_pend_q, row_pend_d;
    logic                      last_jump_q, last_jump_d;
    logic [3:0]                mixer_q, mixer_d;
    logic [1:0]                ch_q, ch_d;
    logic [6:0]                note_q, note_d;
    logic [3:0]                vol_q, vol_d;
    logic                      valid_q, valid_d;
    logic                      fault_q, fault_d;
    logic                      en_prev_q;

    logic [1:0]  op;
    logic [1:0]  ev_ch;
    logic [11:0] payload;
    logic        en_rise;
    logic        handshake;
    logic        wait_dec;

    assign op        = i_rom_data[15:14];
    assign ev_ch     = i_rom_data[13:12];
    assign payload   = i_rom_data[11:0];
    assign en_rise   = i_enable & ~en_prev_q;
    assign handshake = valid_q & i_wr_ready;
    assign wait_dec  = (state_q == S_DECODE) && i_enable && (op == OP_WAIT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            tick_q      <= '0;
            rows_left_q <= '0;
            row_pend_q  <= 1'b0;
            last_jump_q <= 1'b0;
            mixer_q     <= '0;
            ch_q        <= '0;
            note_q      <= '0;
            vol_q       <= '0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            en_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tick_q      <= tick_d;
            rows_left_q <= rows_left_d;
            row_pend_q  <= row_pend_d;
            last_jump_q <= last_jump_d;
            mixer_q     <= mixer_d;
            ch_q        <= ch_d;
            note_q      <= note_d;
            vol_q       <= vol_d;
            valid_q     <= valid_d;
            fault_q     <= fault_d;
            en_prev_q   <= i_enable;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tick_d      = tick_q;
        rows_left_d = rows_left_q;
        row_pend_d  = row_pend_q;
        last_jump_d = last_jump_q;
        mixer_d     = mixer_q;
        ch_d        = ch_q;
        note_d      = note_q;
        vol_d       = vol_q;
        valid_d     = valid_q;
        fault_d     = en_rise ? 1'b0 : fault_q;

        case (state_q)
            S_IDLE: begin
                // a fault parks the sequencer until enable is toggled
                if (i_enable && (!fault_q || en_rise)) begin
                    state_d    = S_FETCH;
                    tick_d     = '0;
                    row_pend_d = 1'b0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_NOTE_ON: begin
                        state_d        = S_ISSUE;
                        ch_d           = ev_ch;
                        note_d         = payload[6:0];
                        vol_d          = payload[11:8];
                        valid_d        = 1'b1;
                        mixer_d[ev_ch] = 1'b1;
                        pc_d           = pc_q + 1'b1;
                        last_jump_d    = 1'b0;
                    end
                    OP_NOTE_OFF: begin
                        state_d        = S_ISSUE;
                        ch_d           = ev_ch;
                        note_d         = '0;
                        vol_d          = '0;
                        valid_d        = 1'b1;
                        mixer_d[ev_ch] = 1'b0;
                        pc_d           = pc_q + 1'b1;
                        last_jump_d    = 1'b0;
                    end
                    OP_WAIT: begin
                        state_d     = S_WAIT_ROW;
                        rows_left_d = (payload == 12'd0) ? 12'd0 : payload - 12'd1;
                        pc_d        = pc_q + 1'b1;
                        last_jump_d = 1'b0;
                    end
                    default: begin
                        if (last_jump_q) begin
                            state_d = S_IDLE;
                            fault_d = 1'b1;
                        end else begin
                            state_d     = S_FETCH;
                            pc_d        = payload[ROM_ADDR_WIDTH-1:0];
                            last_jump_d = 1'b1;
                        end
                    end
                endcase
            end
            S_ISSUE: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    state_d = i_enable ? S_FETCH : S_IDLE;
                end
            end
            S_WAIT_ROW: begin
                if (row_pend_q) begin
                    row_pend_d = 1'b0;
                    if (rows_left_q == 12'd0) state_d = S_FETCH;
                    else rows_left_d = rows_left_q - 12'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!i_enable && state_q != S_ISSUE) state_d = S_IDLE;

        // one stored boundary; one landing on a WAIT decode is dropped
        if (state_q != S_IDLE && i_frame_pulse) begin
            if (tick_q == TICK_MAX) begin
                tick_d = '0;
                if (!wait_dec) row_pend_d = 1'b1;
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
        if (wait_dec) row_pend_d = 1'b0;

        if (state_d == S_IDLE) begin
            pc_d        = '0;
            mixer_d     = '0;
            tick_d      = '0;
            rows_left_d = '0;
            row_pend_d  = 1'b0;
            last_jump_d = 1'b0;
            valid_d     = 1'b0;
        end
    end

    always_comb begin
        o_rom_addr   = pc_q;
        o_wr_valid   = valid_q;
        o_wr_channel = ch_q;
        o_wr_note    = note_q;
        o_wr_volume  = vol_q;
        o_mixer      = mixer_q;
        o_playing    = (state_q != S_IDLE);
        o_fault      = fault_q;
    end

endmodule

// File: tb/tb_apu_song_sequencer.sv
// Directed bench for apu_song_sequencer: small behavioural song ROM with one-cycle
// read latency, hand-computed cycle timing for notes, waits, jumps and stops.
module tb_apu_song_sequencer;

    localparam int AW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_enable;
    logic          i_frame_pulse;
    logic [AW-1:0] o_rom_addr;
    logic [15:0]   i_rom_data;
    logic          o_wr_valid;
    logic          i_wr_ready;
    logic [1:0]    o_wr_channel;
    logic [6:0]    o_wr_note;
    logic [3:0]    o_wr_volume;
    logic [3:0]    o_mixer;
    logic          o_playing;
    logic          o_fault;

    logic [15:0] rom [16];
    int n_checks = 0;
    int n_fail   = 0;
    int xfers    = 0;
    int base;

    apu_song_sequencer #(.ROM_ADDR_WIDTH(AW), .TICKS_PER_ROW(6)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
        .i_frame_pulse(i_frame_pulse), .o_rom_addr(o_rom_addr),
        .i_rom_data(i_rom_data), .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready),
        .o_wr_channel(o_wr_channel), .o_wr_note(o_wr_note), .o_wr_volume(o_wr_volume),
        .o_mixer(o_mixer), .o_playing(o_playing), .o_fault(o_fault)
    );

    always #5 i_clk = ~i_clk;

    initial i_rom_data = '0;
    always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

    always @(posedge i_clk)
        if (i_rst_n && o_wr_valid && i_wr_ready) xfers <= xfers + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic load_song();
        clear_rom();
        rom[0] = 16'h1A30;  // NOTE_ON ch1 vol A note 0x30
        rom[1] = 16'h8002;  // WAIT 2
        rom[2] = 16'h5000;  // NOTE_OFF ch1
        rom[3] = 16'hC000;  // JUMP 0
    endtask

    // n pulses, one every 4 cycles; returns one cycle after the last pulse
    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            i_frame_pulse = 1'b1;
            cyc(1);
            i_frame_pulse = 1'b0;
            if (k != n - 1) cyc(3);
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_enable = 1'b0;
        i_frame_pulse = 1'b0;
        i_wr_ready = 1'b1;
        load_song();
        cyc(2);
        i_rst_n = 1'b1;
        cyc(1);

        check("rst_addr", o_rom_addr, 0);
        check("rst_valid", o_wr_valid, 0);
        check("rst_fields", {o_wr_channel, o_wr_note, o_wr_volume}, 0);
        check("rst_mixer", o_mixer, 0);
        check("rst_playing", o_playing, 0);
        check("rst_fault", o_fault, 0);

        // song with ready held high
        i_enable = 1'b1;
        cyc(3);
        check("on_valid", o_wr_valid, 1);
        check("on_fields", {o_wr_channel, o_wr_note, o_wr_volume}, {2'd1, 7'h30, 4'hA});
        check("on_mixer", o_mixer, 4'b0010);
        check("on_playing", o_playing, 1);
        cyc(1);
        check("fetch1_addr", o_rom_addr, 1);
        check("fetch1_valid", o_wr_valid, 0);
        cyc(2);
        check("wait_addr", o_rom_addr, 2);
        check("wait_mixer", o_mixer, 4'b0010);
        pulses(12);
        cyc(2);
        check("off_not_early", o_wr_valid, 0);
        cyc(1);
        check("off_valid", o_wr_valid, 1);
        check("off_fields", {o_wr_channel, o_wr_note, o_wr_volume}, {2'd1, 7'h00, 4'h0});
        check("off_mixer", o_mixer, 4'b0000);
        cyc(3);
        check("jump_addr", o_rom_addr, 0);
        cyc(2);
        check("loop_valid", o_wr_valid, 1);
        check("loop_note", o_wr_note, 7'h30);
        check("loop_mixer", o_mixer, 4'b0010);

        // stop during WAIT_ROW, then restart
        cyc(3);
        check("wait2_addr", o_rom_addr, 2);
        i_enable = 1'b0;
        cyc(1);
        check("stop_mixer", o_mixer, 0);
        check("stop_addr", o_rom_addr, 0);
        check("stop_playing", o_playing, 0);
        i_enable = 1'b1;
        cyc(1);
        check("restart_addr", o_rom_addr, 0);
        check("restart_playing", o_playing, 1);
        cyc(2);
        check("restart_valid", o_wr_valid, 1);
        check("restart_note", o_wr_note, 7'h30);
        i_enable = 1'b0;
        cyc(2);

        // backpressure
        i_wr_ready = 1'b0;
        i_enable = 1'b1;
        cyc(3);
        base = xfers;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", o_wr_valid, 1);
            check("bp_fields", {o_wr_channel, o_wr_note, o_wr_volume}, {2'd1, 7'h30, 4'hA});
            cyc(1);
        end
        i_wr_ready = 1'b1;
        cyc(1);
        check("bp_xfers", xfers - base, 1);
        check("bp_valid_low", o_wr_valid, 0);
        check("bp_fetch_addr", o_rom_addr, 1);
        i_wr_ready = 1'b0;
        i_enable = 1'b0;
        cyc(1);

        // reset in the middle of a stalled write
        i_enable = 1'b1;
        cyc(3);
        check("pre_rst_valid", o_wr_valid, 1);
        base = xfers;
        i_rst_n = 1'b0;
        cyc(1);
        check("mrst_valid", o_wr_valid, 0);
        check("mrst_mixer", o_mixer, 0);
        check("mrst_addr", o_rom_addr, 0);
        check("mrst_playing", o_playing, 0);
        check("mrst_fields", {o_wr_channel, o_wr_note, o_wr_volume}, 0);
        check("mrst_xfers", xfers - base, 0);
        i_enable = 1'b0;
        i_rst_n = 1'b1;
        i_wr_ready = 1'b1;
        cyc(1);

        // jump loop fault
        clear_rom();
        rom[0] = 16'hC001;
        rom[1] = 16'hC000;
        i_enable = 1'b1;
        cyc(5);
        check("loop_fault", o_fault, 1);
        check("loop_playing", o_playing, 0);
        i_enable = 1'b0;
        cyc(1);
        check("fault_sticky", o_fault, 1);
        i_enable = 1'b1;
        cyc(1);
        check("fault_cleared", o_fault, 0);
        check("fault_restart", o_playing, 1);
        i_enable = 1'b0;
        cyc(2);

        // WAIT 0 behaves as WAIT 1; pc wraps after a NOTE_ON at the top address
        clear_rom();
        rom[0]  = 16'hC00E;  // JUMP 14
        rom[14] = 16'h8000;  // WAIT 0
        rom[15] = 16'h2511;  // NOTE_ON ch2 vol 5 note 0x11
        i_enable = 1'b1;
        cyc(5);
        check("w0_addr", o_rom_addr, 15);
        pulses(6);
        cyc(2);
        check("w0_not_early", o_wr_valid, 0);
        cyc(1);
        check("w0_valid", o_wr_valid, 1);
        check("w0_fields", {o_wr_channel, o_wr_note, o_wr_volume}, {2'd2, 7'h11, 4'h5});
        check("w0_mixer", o_mixer, 4'b0100);
        cyc(1);
        check("wrap_addr", o_rom_addr, 0);
        i_enable = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
